stopwatch_counter: RTL and testbench

Time-keeping core of the stopwatch: divides the system clock to a 10 ms tick, counts elapsed time in eight BCD digits (HH:MM:SS.cc), and handles start/stop, clear and lap-freeze buttons. It sits directly upstream of the 8-way digit chooser, supplying its eight 4-bit digit inputs. The scan select and 7-segment decode stay downstream.

---
 rtl/stopwatch_pkg.sv | 20 ++
 rtl/bcd_digit.sv | 40 ++++
 rtl/stopwatch_counter.sv | 158 +++++++++++++++
 tb/tb_stopwatch_counter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch time-keeping core.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_e;

    localparam int unsigned TICK_DIV_DEFAULT = 500000;
    localparam int unsigned NUM_DIGITS       = 8;
    localparam int unsigned DIGIT_W          = 4;
    localparam int unsigned DISP_W           = NUM_DIGITS * DIGIT_W;
    localparam int unsigned NUM_BTN          = 3;

    // Per-digit wrap values: decimal digits roll at 9, tens of sec/min at 5.
    localparam logic [DIGIT_W-1:0] MAX_DEC = 4'd9;
    localparam logic [DIGIT_W-1:0] MAX_SEX = 4'd5;

endpackage

// File: rtl/bcd_digit.sv
// One BCD counter digit: wraps at MAX and emits a carry on the wrapping increment.
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] MAX = MAX_DEC
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               inc,
    output logic [DIGIT_W-1:0] q,
    output logic               carry
);

    logic [DIGIT_W-1:0] q_q;
    logic [DIGIT_W-1:0] q_d;

    // Next digit value: clear beats increment; anything at or past MAX wraps to 0.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc) begin
            q_d = (q_q >= MAX) ? '0 : DIGIT_W'(q_q + DIGIT_W'(1));
        end
    end

    // Digit register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q     = q_q;
    assign carry = inc & (q_q == MAX);

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch core: button conditioning, run/pause FSM, 10 ms prescaler,
// HH:MM:SS.cc BCD cascade and lap freeze.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_stop,
    input  logic               clear,
    input  logic               lap,
    output logic [DIGIT_W-1:0] data1,
    output logic [DIGIT_W-1:0] data2,
    output logic [DIGIT_W-1:0] data3,
    output logic [DIGIT_W-1:0] data4,
    output logic [DIGIT_W-1:0] data5,
    output logic [DIGIT_W-1:0] data6,
    output logic [DIGIT_W-1:0] data7,
    output logic [DIGIT_W-1:0] data8,
    output logic               running,
    output logic               frozen
);

    localparam int unsigned    PRE_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    // Button index map: 0 = start_stop, 1 = clear, 2 = lap.
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_pulse;
    logic               clr_p;
    logic               ss_p;
    logic               lap_p;

    state_e             state_q, state_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic               tick;
    logic [DISP_W-1:0]  live;
    logic [DISP_W-1:0]  lap_q, lap_d;
    logic               frozen_q, frozen_d;
    logic [NUM_DIGITS-2:0] carry;
    logic               carry_unused;
    logic [DISP_W-1:0]  disp;

    assign btn_raw = {lap, clear, start_stop};

    // Two-flop synchronizer plus rising-edge detector per button.
    for (genvar b = 0; b < int'(NUM_BTN); b++) begin : g_btn
        logic [1:0] sync_q;
        logic       prev_q;

        // Sync chain and previous-level register.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q <= '0;
                prev_q <= 1'b0;
            end else begin
                sync_q <= {sync_q[0], btn_raw[b]};
                prev_q <= sync_q[1];
            end
        end

        assign btn_pulse[b] = sync_q[1] & ~prev_q;
    end

    // Same-cycle priority: clear > start_stop > lap.
    assign clr_p = btn_pulse[1];
    assign ss_p  = btn_pulse[0] & ~btn_pulse[1];
    assign lap_p = btn_pulse[2] & ~btn_pulse[1] & ~btn_pulse[0];

    // Tick is qualified by the current state, before any transition.
    assign tick = (state_q == RUN) && (pre_q == PRE_LAST);

    // Next-state, prescaler and lap-freeze logic.
    always_comb begin
        state_d  = state_q;
        pre_d    = pre_q;
        lap_d    = lap_q;
        frozen_d = frozen_q;

        if (clr_p) begin
            state_d = IDLE;
        end else if (ss_p) begin
            case (state_q)
                IDLE:    state_d = RUN;
                RUN:     state_d = PAUSE;
                PAUSE:   state_d = RUN;
                default: state_d = IDLE;
            endcase
        end

        if (clr_p || (state_q == IDLE)) begin
            pre_d = '0;
        end else if (state_q == RUN) begin
            pre_d = tick ? '0 : PRE_W'(pre_q + PRE_W'(1));
        end

        if (clr_p) begin
            frozen_d = 1'b0;
        end else if (lap_p) begin
            if (frozen_q) begin
                if (state_q != IDLE) begin
                    frozen_d = 1'b0;
                end
            end else if (state_q == RUN) begin
                frozen_d = 1'b1;
                lap_d    = live;
            end
        end
    end

    // Control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pre_q    <= '0;
            lap_q    <= '0;
            frozen_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            lap_q    <= lap_d;
            frozen_q <= frozen_d;
        end
    end

    // Digit cascade, least significant first; carries ripple within the tick cycle.
    bcd_digit #(.MAX(MAX_DEC)) u_d1 (.clk(clk), .rst_n(rst_n), .clr(clr_p), .inc(tick),
                                     .q(live[3:0]),   .carry(carry[0]));
    bcd_digit #(.MAX(MAX_DEC)) u_d2 (.clk(clk), .rst_n(rst_n), .clr(clr_p), .inc(carry[0]),
                                     .q(live[7:4]),   .carry(carry[1]));
    bcd_digit #(.MAX(MAX_DEC)) u_d3 (.clk(clk), .rst_n(rst_n), .clr(clr_p), .inc(carry[1]),
                                     .q(live[11:8]),  .carry(carry[2]));
    bcd_digit #(.MAX(MAX_SEX)) u_d4 (.clk(clk), .rst_n(rst_n), .clr(clr_p), .inc(carry[2]),
                                     .q(live[15:12]), .carry(carry[3]));
    bcd_digit #(.MAX(MAX_DEC)) u_d5 (.clk(clk), .rst_n(rst_n), .clr(clr_p), .inc(carry[3]),
                                     .q(live[19:16]), .carry(carry[4]));
    bcd_digit #(.MAX(MAX_SEX)) u_d6 (.clk(clk), .rst_n(rst_n), .clr(clr_p), .inc(carry[4]),
                                     .q(live[23:20]), .carry(carry[5]));
    bcd_digit #(.MAX(MAX_DEC)) u_d7 (.clk(clk), .rst_n(rst_n), .clr(clr_p), .inc(carry[5]),
                                     .q(live[27:24]), .carry(carry[6]));
    bcd_digit #(.MAX(MAX_DEC)) u_d8 (.clk(clk), .rst_n(rst_n), .clr(clr_p), .inc(carry[6]),
                                     .q(live[31:28]), .carry(carry_unused));

    // Display: held lap value while frozen, otherwise the live count.
    assign disp    = frozen_q ? lap_q : live;
    assign data1   = disp[3:0];
    assign data2   = disp[7:4];
    assign data3   = disp[11:8];
    assign data4   = disp[15:12];
    assign data5   = disp[19:16];
    assign data6   = disp[23:20];
    assign data7   = disp[27:24];
    assign data8   = disp[31:28];
    assign running = (state_q == RUN);
    assign frozen  = frozen_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter with TICK_DIV=4.
module tb_stopwatch_counter;

    logic       clk;
    logic       rst_n;
    logic       start_stop;
    logic       clear;
    logic       lap;
    logic [3:0] data1, data2, data3, data4, data5, data6, data7, data8;
    logic       running;
    logic       frozen;

    int n_tests;
    int n_fail;
    logic [31:0] force_val;

    stopwatch_counter #(.TICK_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .start_stop(start_stop), .clear(clear), .lap(lap),
        .data1(data1), .data2(data2), .data3(data3), .data4(data4),
        .data5(data5), .data6(data6), .data7(data7), .data8(data8),
        .running(running), .frozen(frozen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ss;
        logic        clr;
        logic        lp;
        int unsigned wait_cyc;
        logic [31:0] exp_d;
        logic        exp_run;
        logic        exp_frz;
        string       name;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [31:0] disp();
        return {data8, data7, data6, data5, data4, data3, data2, data1};
    endfunction

    task automatic check(input string name, input logic [31:0] exp_d,
                         input logic exp_run, input logic exp_frz);
        n_tests++;
        if (disp() !== exp_d) begin
            n_fail++;
            $display("FAIL %s digits: got %h expected %h", name, disp(), exp_d);
        end
        n_tests++;
        if (running !== exp_run) begin
            n_fail++;
            $display("FAIL %s running: got %b expected %b", name, running, exp_run);
        end
        n_tests++;
        if (frozen !== exp_frz) begin
            n_fail++;
            $display("FAIL %s frozen: got %b expected %b", name, frozen, exp_frz);
        end
    endtask

    // Button high across edge 1 only; action lands on edge 3; returns at the negedge after it.
    task automatic press(input logic s, input logic c, input logic l);
        start_stop = s;
        clear      = c;
        lap        = l;
        @(posedge clk);
        @(negedge clk);
        start_stop = 1'b0;
        clear      = 1'b0;
        lap        = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_cyc(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // Preload the live digits while paused; one held edge makes the value stick.
    task automatic preload(input logic [31:0] v);
        force_val = v;
        force dut.u_d1.q_q = force_val[3:0];
        force dut.u_d2.q_q = force_val[7:4];
        force dut.u_d3.q_q = force_val[11:8];
        force dut.u_d4.q_q = force_val[15:12];
        force dut.u_d5.q_q = force_val[19:16];
        force dut.u_d6.q_q = force_val[23:20];
        force dut.u_d7.q_q = force_val[27:24];
        force dut.u_d8.q_q = force_val[31:28];
        @(posedge clk);
        @(negedge clk);
        release dut.u_d1.q_q;
        release dut.u_d2.q_q;
        release dut.u_d3.q_q;
        release dut.u_d4.q_q;
        release dut.u_d5.q_q;
        release dut.u_d6.q_q;
        release dut.u_d7.q_q;
        release dut.u_d8.q_q;
        #1;
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        force_val  = '0;
        rst_n      = 1'b0;
        start_stop = 1'b0;
        clear      = 1'b0;
        lap        = 1'b0;

        // Run-edge count R gives ticks = R/4; expectations below are derived from it.
        vecs[0]  = '{1'b0, 1'b0, 1'b0,   2, 32'h0000_0000, 1'b0, 1'b0, "reset"};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 400, 32'h0000_0100, 1'b1, 1'b0, "run_100_ticks"};
        vecs[2]  = '{1'b1, 1'b0, 1'b0,  50, 32'h0000_0100, 1'b0, 1'b0, "pause_hold"};
        vecs[3]  = '{1'b1, 1'b0, 1'b0,   1, 32'h0000_0101, 1'b1, 1'b0, "resume_tick"};
        vecs[4]  = '{1'b0, 1'b0, 1'b1,   0, 32'h0000_0101, 1'b1, 1'b1, "lap_freeze"};
        vecs[5]  = '{1'b0, 1'b0, 1'b0,  40, 32'h0000_0101, 1'b1, 1'b1, "lap_hold"};
        vecs[6]  = '{1'b0, 1'b0, 1'b1,   0, 32'h0000_0112, 1'b1, 1'b0, "lap_unfreeze"};
        vecs[7]  = '{1'b1, 1'b1, 1'b0,   5, 32'h0000_0000, 1'b0, 1'b0, "clear_beats_ss"};
        vecs[8]  = '{1'b0, 1'b0, 1'b1,   3, 32'h0000_0000, 1'b0, 1'b0, "lap_idle_ignored"};
        vecs[9]  = '{1'b1, 1'b0, 1'b0,   7, 32'h0000_0001, 1'b1, 1'b0, "first_tick"};
        vecs[10] = '{1'b1, 1'b0, 1'b1,   4, 32'h0000_0002, 1'b0, 1'b0, "ss_beats_lap"};
        vecs[11] = '{1'b1, 1'b0, 1'b0,   2, 32'h0000_0003, 1'b1, 1'b0, "resume_again"};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].ss || vecs[i].clr || vecs[i].lp)
                press(vecs[i].ss, vecs[i].clr, vecs[i].lp);
            wait_cyc(vecs[i].wait_cyc);
            check(vecs[i].name, vecs[i].exp_d, vecs[i].exp_run, vecs[i].exp_frz);
        end

        // Partial tick survives a pause: 3 ticks + 2 cycles, pause, resume.
        press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        wait_cyc(11);
        press(1'b1, 1'b0, 1'b0);
        wait_cyc(50);
        check("partial_paused", 32'h0000_0003, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        wait_cyc(1);
        check("partial_resume1", 32'h0000_0003, 1'b1, 1'b0);
        wait_cyc(1);
        check("partial_resume2", 32'h0000_0004, 1'b1, 1'b0);

        // Lap at 00.12, hold while counting, release shows live 00.23.
        press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        wait_cyc(46);
        press(1'b0, 1'b0, 1'b1);
        check("lap12_capture", 32'h0000_0012, 1'b1, 1'b1);
        wait_cyc(40);
        check("lap12_hold", 32'h0000_0012, 1'b1, 1'b1);
        press(1'b0, 1'b0, 1'b1);
        check("lap12_release", 32'h0000_0023, 1'b1, 1'b0);

        // Clear on the same edge as a tick.
        press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        wait_cyc(5);
        check("pre_clear_tick", 32'h0000_0001, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        check("clear_on_tick", 32'h0000_0000, 1'b0, 1'b0);

        // 00:59:59.99 + 1 tick -> 01:00:00.00.
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        preload(32'h0059_5999);
        check("preload_hour", 32'h0059_5999, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        wait_cyc(1);
        check("hour_carry", 32'h0100_0000, 1'b1, 1'b0);

        // 99:59:59.99 + 1 tick -> all zero, still running.
        press(1'b1, 1'b0, 1'b0);
        preload(32'h9959_5999);
        check("preload_full", 32'h9959_5999, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        wait_cyc(1);
        check("full_wrap", 32'h0000_0000, 1'b1, 1'b0);

        // Asynchronous reset mid-count while frozen.
        wait_cyc(20);
        press(1'b0, 1'b0, 1'b1);
        check("pre_reset_frozen", 32'h0000_0005, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 32'h0000_0000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(3);
        check("post_reset_idle", 32'h0000_0000, 1'b0, 1'b0);

        // A held button yields a single press.
        start_stop = 1'b1;
        wait_cyc(10);
        start_stop = 1'b0;
        wait_cyc(2);
        check("held_button", 32'h0000_0002, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
